// File: rtl/adder_arbiter.sv
// Round-robin arbiter feeding one shared approximate adder into a single-entry
// result register. Also holds the team Adder (AXA3 low cells, exact high cells).

module adder #(
    parameter  int AXA = 3,
    parameter  int FA  = 5,
    localparam int W   = AXA + FA
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [AXA-1:0] sum_lo;
    logic [AXA:0]   carry;
    logic [FA:0]    hi;

    // AXA3 cell: sum = cin & xnor(a,b); carry is kept exact
    always_comb begin
        carry[0] = cin;
        for (int unsigned i = 0; i < AXA; i++) begin
            sum_lo[i]    = carry[i] & ~(a[i] ^ b[i]);
            carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        hi   = {1'b0, a[W-1:AXA]} + {1'b0, b[W-1:AXA]} + {{FA{1'b0}}, carry[AXA]};
        sum  = {hi[FA-1:0], sum_lo};
        cout = hi[FA];
    end
endmodule

module adder_arbiter #(
    parameter  int AXA  = 3,
    parameter  int FA   = 5,
    parameter  int NREQ = 4,
    localparam int W    = AXA + FA,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;

    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic           slot_free;
    logic           hs;
    logic [W-1:0]   a_sel, b_sel;
    logic           cin_sel;
    logic [W-1:0]   add_sum;
    logic           add_cout;

    always_comb begin
        int unsigned idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(idx);
            end
        end
    end

    // rst gates the handshake so no grant leaks out while reset is held
    assign slot_free = (state_q == EMPTY) || rsp_ready;
    assign hs        = gnt_found && slot_free && !rst;

    always_comb begin
        req_ready = '0;
        if (hs) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        cin_sel = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == gnt_idx) begin
                a_sel   = req_a[i*W +: W];
                b_sel   = req_b[i*W +: W];
                cin_sel = req_cin[i];
            end
        end
    end

    adder #(.AXA(AXA), .FA(FA)) u_adder (
        .a    (a_sel),
        .b    (b_sel),
        .cin  (cin_sel),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (hs) begin
            state_d = FULL;
            id_d    = gnt_idx;
            sum_d   = add_sum;
            cout_d  = add_cout;
            ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            id_q    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed vector table, hand-written reset sequence, then a randomised run
// against a reference model of the arbiter and the AXA3 adder.

module tb_adder_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [3:0]  req_cin = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_sum;
    logic        rsp_cout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adder_arbiter #(.AXA(3), .FA(5), .NREQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    typedef struct {
        logic [3:0] valid;
        logic       rr;
        logic [3:0] ready;
        logic       rv;
        logic [1:0] id;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic rv, input logic [1:0] id,
                           input logic [7:0] sum, input logic cout);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(rv));
        chk({tag, " rsp_id"},    32'(rsp_id),    32'(id));
        chk({tag, " rsp_sum"},   32'(rsp_sum),   32'(sum));
        chk({tag, " rsp_cout"},  32'(rsp_cout),  32'(cout));
    endtask

    function automatic vec_t mk(logic [3:0] v, logic rr, logic [3:0] rdy, logic rv,
                                logic [1:0] id, logic [7:0] s, logic c);
        vec_t t;
        t.valid = v; t.rr = rr; t.ready = rdy; t.rv = rv; t.id = id; t.sum = s; t.cout = c;
        return t;
    endfunction

    function automatic logic [8:0] model_add(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic       cy;
        logic [7:0] s;
        logic [5:0] hi;
        cy = c;
        for (int i = 0; i < 3; i++) begin
            s[i] = cy & ~(a[i] ^ b[i]);
            cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        hi = {1'b0, a[7:3]} + {1'b0, b[7:3]} + {5'b0, cy};
        s[7:3] = hi[4:0];
        return {hi[5], s};
    endfunction

    initial begin
        logic       m_full;
        logic [1:0] m_ptr, m_id;
        logic [7:0] m_sum;
        logic       m_cout;
        logic [8:0] r;
        int         g;
        logic       found;
        logic [3:0] exp_rdy;
        int         starve[4];
        int         starve_max;

        // Operands per requester: 0: F0+20+0=10 c1, 1: 13+05+1=19 c0,
        // 2: 07+00+0=00 c0 (approx), 3: FF+01+0=00 c1
        req_a   = {8'hFF, 8'h07, 8'h13, 8'hF0};
        req_b   = {8'h01, 8'h00, 8'h05, 8'h20};
        req_cin = 4'b0010;

        tbl[0]  = mk(4'b0000, 1, 4'b0000, 0, 0, 8'h00, 0);
        tbl[1]  = mk(4'b0001, 1, 4'b0001, 0, 0, 8'h00, 0);
        tbl[2]  = mk(4'b0000, 0, 4'b0000, 1, 0, 8'h10, 1);
        tbl[3]  = mk(4'b0110, 0, 4'b0000, 1, 0, 8'h10, 1);
        tbl[4]  = mk(4'b0110, 0, 4'b0000, 1, 0, 8'h10, 1);
        tbl[5]  = mk(4'b0110, 0, 4'b0000, 1, 0, 8'h10, 1);
        tbl[6]  = mk(4'b0110, 1, 4'b0010, 1, 0, 8'h10, 1);
        tbl[7]  = mk(4'b1111, 1, 4'b0100, 1, 1, 8'h19, 0);
        tbl[8]  = mk(4'b1111, 1, 4'b1000, 1, 2, 8'h00, 0);
        tbl[9]  = mk(4'b1111, 1, 4'b0001, 1, 3, 8'h00, 1);
        tbl[10] = mk(4'b1111, 1, 4'b0010, 1, 0, 8'h10, 1);
        tbl[11] = mk(4'b0000, 1, 4'b0000, 1, 1, 8'h19, 0);
        tbl[12] = mk(4'b0000, 1, 4'b0000, 0, 1, 8'h19, 0);
        tbl[13] = mk(4'b0100, 0, 4'b0100, 0, 1, 8'h19, 0);
        tbl[14] = mk(4'b0101, 0, 4'b0000, 1, 2, 8'h00, 0);
        tbl[15] = mk(4'b0101, 1, 4'b0001, 1, 2, 8'h00, 0);
        tbl[16] = mk(4'b0101, 1, 4'b0100, 1, 0, 8'h10, 1);
        tbl[17] = mk(4'b0000, 1, 4'b0000, 1, 2, 8'h00, 0);
        tbl[18] = mk(4'b0000, 1, 4'b0000, 0, 2, 8'h00, 0);

        // Reset held: no grant even with requests pending
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        chk("reset req_ready", 32'(req_ready), 32'h0);
        chk_rsp("reset", 0, 0, 8'h00, 0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;

        foreach (tbl[i]) begin
            @(negedge clk);
            req_valid = tbl[i].valid;
            rsp_ready = tbl[i].rr;
            #1;
            chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(tbl[i].ready));
            chk_rsp($sformatf("v%0d", i), tbl[i].rv, tbl[i].id, tbl[i].sum, tbl[i].cout);
        end

        // Async reset while FULL, then restart search from index 0
        @(negedge clk);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        #1;
        chk("pre-rst req_ready", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        chk("pre-rst rsp_valid", 32'(rsp_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid-rst req_ready", 32'(req_ready), 32'h0);
        chk_rsp("mid-rst", 0, 0, 8'h00, 0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 4'b0011;
        rsp_ready = 1'b1;
        #1;
        chk("post-rst req_ready", 32'(req_ready), 32'b0001);
        chk("post-rst rsp_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        chk("rst seq g3 req_ready", 32'(req_ready), 32'b1000);
        chk_rsp("rst seq g3", 1, 0, 8'h10, 1);
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        chk("rst seq ptr0 req_ready", 32'(req_ready), 32'b0001);
        chk_rsp("rst seq ptr0", 1, 3, 8'h00, 1);
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b1;

        // After this drain: EMPTY, ptr=1, last result id0 / 10 / 1
        m_full = 1'b0; m_ptr = 2'd1; m_id = 2'd0; m_sum = 8'h10; m_cout = 1'b1;
        foreach (starve[i]) starve[i] = 0;
        starve_max = 0;

        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            req_valid = 4'($urandom);
            rsp_ready = 1'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
            req_cin   = 4'($urandom);
            #1;
            found = 1'b0;
            g     = 0;
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (int'(m_ptr) + k) % 4;
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
            found   = found && (!m_full || rsp_ready);
            exp_rdy = found ? 4'(1 << g) : 4'b0000;
            chk("rand req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("rand onehot0", 32'($onehot0(req_ready)), 32'h1);
            chk_rsp("rand", m_full, m_id, m_sum, m_cout);
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] || (found && g == i)) starve[i] = 0;
                else if (found) starve[i]++;
                if (starve[i] > starve_max) starve_max = starve[i];
            end
            if (found) begin
                r      = model_add(req_a[g*8 +: 8], req_b[g*8 +: 8], req_cin[g]);
                m_sum  = r[7:0];
                m_cout = r[8];
                m_id   = 2'(g);
                m_full = 1'b1;
                m_ptr  = 2'((g + 1) % 4);
            end else if (m_full && rsp_ready) begin
                m_full = 1'b0;
            end
        end
        chk("starvation bound", 32'(starve_max < 4), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter AXA, default 3: number of low-order approximate (AXA3) bit cells in the shared adder.
REQ-002 Parameter FA, default 5: number of high-order exact full-adder bit cells; operand width W = AXA+FA.
REQ-003 Parameter NREQ, default 4: number of requesters; IDW = clog2(NREQ), minimum 1.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 req_valid  input  NREQ  per-requester operand valid.
REQ-007 req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-008 req_a  input  NREQ*W  operand A, requester i at bits [i*W +: W].
REQ-009 req_b  input  NREQ*W  operand B, same packing as req_a.
REQ-010 req_cin  input  NREQ  carry-in per requester.
REQ-011 rsp_valid  output  1  result register holds a valid result.
REQ-012 rsp_ready  input  1  downstream accepts the result.
REQ-013 rsp_id  output  IDW  index of the requester that owns the result.
REQ-014 rsp_sum  output  W  sum from the shared adder.
REQ-015 rsp_cout  output  1  carry-out from the shared adder.

Function
REQ-016 The block SHALL contain exactly one instance of the team Adder (AXA approximate low bits, FA exact high bits), shared by all requesters.
REQ-017 The adder SHALL be combinationally fed by the muxed operands of the granted requester.
REQ-018 State machine SHALL have two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
REQ-019 Slot-free SHALL be defined as (state==EMPTY) or (state==FULL and rsp_ready=1).
REQ-020 Grant SHALL be issued only when slot-free and at least one req_valid is high.
REQ-021 Grant selection SHALL be round-robin:
  - Search starts at pointer ptr and proceeds upward with wrap-around modulo NREQ.
  - The first requester found with req_valid=1 is granted.
REQ-022 req_ready[g] SHALL be 1 for the granted index g only, in the same cycle; a handshake is req_valid[g] and req_ready[g] both high.
REQ-023 On a handshake, the following SHALL occur at the next edge:
  - {rsp_sum, rsp_cout} loaded with the Adder outputs for req_a[g], req_b[g], req_cin[g].
  - rsp_id loaded with g.
  - State set to FULL.
  - ptr set to (g+1) mod NREQ.
REQ-024 Latency SHALL be one cycle from handshake to rsp_valid; sustained throughput SHALL be one result per cycle when rsp_ready is held high.
REQ-025 Simultaneous drain and accept (FULL, rsp_ready=1, new handshake) SHALL replace the result and keep state FULL, with no bubble.
REQ-026 Drain without a new handshake SHALL move FULL to EMPTY; rsp_sum, rsp_cout and rsp_id hold their last values.
REQ-027 While FULL and rsp_ready=0, all req_ready SHALL be 0, and rsp_sum, rsp_cout and rsp_id SHALL be held stable.
REQ-028 ptr SHALL change only on a handshake; an idle cycle leaves ptr unchanged.
REQ-029 A requester whose req_valid drops before a handshake SHALL lose no state; no request is latched before the handshake.
REQ-030 The arithmetic result SHALL be bit-identical to the standalone Adder with the same parameters, including approximate low bits.

Reset
REQ-031 rst=1 SHALL immediately force state=EMPTY, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, ptr=0, and req_ready=0.
REQ-032 Reset asserted mid-operation SHALL discard a pending FULL result; no response is produced for it.
REQ-033 The first grant after reset release SHALL search from index 0.

Verification
REQ-034 Single request: reset, then req_valid=0001, a=0xF0, b=0x20, cin=0 -> req_ready=0001 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_sum=0x10, rsp_cout=1.
REQ-035 Round-robin: req_valid=1111 held and rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; rsp_id follows one cycle later, with no bubbles.
REQ-036 Backpressure: result FULL and rsp_ready=0 for 3 cycles with req_valid=0110 -> req_ready=0 and outputs stable; on rsp_ready=1, requester 1 is granted in the same cycle.
REQ-037 Wrap-around: ptr=3 (after a grant to 2) and req_valid=0101 -> requester 0 is granted, then ptr=1.
REQ-038 Async reset: assert rst mid-cycle while FULL -> rsp_valid falls before the next edge; after release with req_valid=1000, the grant goes to 3 and ptr becomes 0.
REQ-039 Random: 10k cycles of random valid, operands and rsp_ready -> every result matches the Adder model, no requester starves beyond NREQ grants, and req_ready is always one-hot or zero.
